// File: rtl/bcd_pkg.sv
// Shared types and constants for the digit-serial BCD adder: controller states,
// the BCD nibble type and the decimal-correction constants.
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef logic [3:0] bcd_t;

  localparam bcd_t BCD_MAX  = 4'd9;
  localparam bcd_t BCD_CORR = 4'd6;

endpackage

// File: rtl/bcd_serial_adder_ctrl_if.sv
// Operand and result channels of the serial BCD adder, bundled with
// producer/consumer (master) and adder (slave) views.
interface bcd_serial_adder_ctrl_if #(
  parameter int DIGITS = 8
);

  // Both channels: a transfer happens on the rising edge where valid and ready
  // are both high; once raised, valid and its payload hold until that edge.
  logic                  in_valid;
  logic                  in_ready;
  logic [4*DIGITS-1:0]   a;
  logic [4*DIGITS-1:0]   b;
  logic                  cin;
  logic                  out_valid;
  logic                  out_ready;
  logic [4*DIGITS-1:0]   sum;
  logic                  cout;
  logic                  err;

  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout, err
  );

  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout, err
  );

endinterface

// File: rtl/bcd_digit_add.sv
// One-digit BCD adder: binary add plus decimal correction. Non-BCD nibbles
// go through the same rule so results stay deterministic; they raise invalid.
module bcd_digit_add
  import bcd_pkg::*;
(
  input  bcd_t a_d,
  input  bcd_t b_d,
  input  logic c_in,
  output bcd_t s_d,
  output logic c_out,
  output logic invalid
);

  logic [4:0] s;

  always_comb begin
    s       = {1'b0, a_d} + {1'b0, b_d} + {4'b0000, c_in};
    s_d     = s[3:0];
    c_out   = 1'b0;
    // (s + 6) mod 16 only depends on the low nibble of s
    if (s > {1'b0, BCD_MAX}) begin
      s_d   = s[3:0] + BCD_CORR;
      c_out = 1'b1;
    end
    invalid = (a_d > BCD_MAX) || (b_d > BCD_MAX);
  end

endmodule

// File: rtl/bcd_serial_adder_ctrl.sv
// Digit-serial BCD adder controller: latches two packed operands and walks the
// shared digit adder from the least-significant digit up, one digit per cycle.
module bcd_serial_adder_ctrl
  import bcd_pkg::*;
#(
  parameter int DIGITS = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  bcd_serial_adder_ctrl_if.slave    bus,
  output state_t                    dbg_state
);

  localparam int W     = 4 * DIGITS;
  localparam int CNT_W = $clog2(DIGITS);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIGITS - 1);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [W-1:0]     a_q;
  logic [W-1:0]     b_q;
  logic             carry_q;
  logic [W-1:0]     sum_q;
  logic             cout_q;
  logic             err_q;

  logic             accept;
  logic             last_digit;
  bcd_t             a_dig;
  bcd_t             b_dig;
  bcd_t             s_dig;
  logic             c_dig;
  logic             inv_dig;

  assign bus.in_ready  = (state == IDLE) && rst_n;
  assign bus.out_valid = (state == DONE);
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
  assign bus.err       = err_q;
  assign dbg_state     = state;

  assign accept     = bus.in_valid && bus.in_ready;
  assign last_digit = (cnt == LAST);
  assign a_dig      = a_q[{cnt, 2'b00} +: 4];
  assign b_dig      = b_q[{cnt, 2'b00} +: 4];

  bcd_digit_add u_digit (
    .a_d     (a_dig),
    .b_d     (b_dig),
    .c_in    (carry_q),
    .s_d     (s_dig),
    .c_out   (c_dig),
    .invalid (inv_dig)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept)        state_nxt = RUN;
      RUN:     if (last_digit)    state_nxt = DONE;
      DONE:    if (bus.out_ready) state_nxt = IDLE;
      default:                    state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Result registers only move in IDLE (clear on accept) and RUN, so they are
  // frozen for the whole time out_valid is high.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            a_q     <= bus.a;
            b_q     <= bus.b;
            carry_q <= bus.cin;
            cnt     <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            err_q   <= 1'b0;
          end
        end
        RUN: begin
          sum_q[{cnt, 2'b00} +: 4] <= s_dig;
          carry_q                  <= c_dig;
          err_q                    <= err_q | inv_dig;
          if (last_digit) cout_q <= c_dig;
          else            cnt    <= cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_serial_adder_ctrl.sv
// Directed bench for the serial BCD adder with DIGITS = 4; expected results are
// hand-computed constants queued per operation.
module tb_bcd_serial_adder_ctrl;
  import bcd_pkg::*;

  localparam int DIGITS = 4;
  localparam int W      = 4 * DIGITS;

  logic   clk = 1'b0;
  logic   rst_n = 1'b0;
  state_t dbg_state;

  bcd_serial_adder_ctrl_if #(.DIGITS(DIGITS)) bus ();

  bcd_serial_adder_ctrl #(.DIGITS(DIGITS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  logic [W+1:0] exp_q[$];   // {err, cout, sum}

  // ---------------- driver tasks (start and end on a negedge) ----------------
  task automatic drive_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic c);
    bus.a        = av;
    bus.b        = bv;
    bus.cin      = c;
    bus.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_result(output int lat, output logic [W+1:0] res);
    lat = 0;
    while (bus.out_valid !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    res = {bus.err, bus.cout, bus.sum};
  endtask

  task automatic handshake();
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_cmp++;
    if (bus.in_ready !== 1'b0) begin n_err++; $display("FAIL reset_in_ready: got %b want 0", bus.in_ready); end
    n_cmp++;
    if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
    n_cmp++;
    if ({bus.err, bus.cout, bus.sum} !== 18'h0) begin
      n_err++; $display("FAIL reset_outputs: got %h want 0", {bus.err, bus.cout, bus.sum});
    end
    n_cmp++;
    if (dbg_state !== IDLE) begin n_err++; $display("FAIL reset_state: got %0d want %0d", dbg_state, IDLE); end
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL reset_release_ready: got %b want 1", bus.in_ready); end
  endtask

  task automatic test_basic();
    int lat;
    logic [W+1:0] res, exp;
    exp_q.push_back({1'b0, 1'b1, 16'h0000});
    drive_op(16'h1234, 16'h8766, 1'b0);
    wait_result(lat, res);
    exp = exp_q.pop_front();
    n_cmp++;
    if (lat !== 4) begin n_err++; $display("FAIL basic_latency: got %0d want 4", lat); end
    n_cmp++;
    if (res !== exp) begin n_err++; $display("FAIL basic_result: got %h want %h", res, exp); end
    handshake();
    n_cmp++;
    if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL basic_ready_after: got %b want 1", bus.in_ready); end
  endtask

  task automatic test_ripple();
    int lat;
    logic [W+1:0] res, exp;
    exp_q.push_back({1'b0, 1'b1, 16'h0000});
    exp_q.push_back({1'b0, 1'b1, 16'h9999});
    drive_op(16'h9999, 16'h0000, 1'b1);
    wait_result(lat, res);
    exp = exp_q.pop_front();
    n_cmp++;
    if (res !== exp) begin n_err++; $display("FAIL ripple_9999_0: got %h want %h", res, exp); end
    handshake();
    drive_op(16'h9999, 16'h9999, 1'b1);
    wait_result(lat, res);
    exp = exp_q.pop_front();
    n_cmp++;
    if (res !== exp) begin n_err++; $display("FAIL ripple_9999_9999: got %h want %h", res, exp); end
    handshake();
  endtask

  task automatic test_back_to_back();
    int lat;
    logic [W+1:0] res, exp;
    exp_q.push_back({1'b0, 1'b0, 16'h0082});
    exp_q.push_back({1'b0, 1'b0, 16'h0002});
    drive_op(16'h0045, 16'h0037, 1'b0);
    wait_result(lat, res);
    exp = exp_q.pop_front();
    n_cmp++;
    if (res !== exp) begin n_err++; $display("FAIL b2b_first: got %h want %h", res, exp); end
    handshake();
    n_cmp++;
    if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL b2b_ready: got %b want 1", bus.in_ready); end
    drive_op(16'h0001, 16'h0001, 1'b0);
    n_cmp++;
    if (dbg_state !== RUN) begin n_err++; $display("FAIL b2b_accept: got %0d want %0d", dbg_state, RUN); end
    wait_result(lat, res);
    exp = exp_q.pop_front();
    n_cmp++;
    if (lat !== 4) begin n_err++; $display("FAIL b2b_latency: got %0d want 4", lat); end
    n_cmp++;
    if (res !== exp) begin n_err++; $display("FAIL b2b_second: got %h want %h", res, exp); end
    handshake();
  endtask

  task automatic test_backpressure();
    int lat;
    logic [W+1:0] res, exp;
    exp_q.push_back({1'b0, 1'b0, 16'h0579});
    drive_op(16'h0123, 16'h0456, 1'b0);
    wait_result(lat, res);
    exp = exp_q.pop_front();
    n_cmp++;
    if (res !== exp) begin n_err++; $display("FAIL bp_result: got %h want %h", res, exp); end
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = (i == 2);
      bus.a        = 16'h9999;
      bus.b        = 16'h9999;
      bus.cin      = 1'b1;
      n_cmp++;
      if (bus.in_ready !== 1'b0) begin n_err++; $display("FAIL bp_in_ready[%0d]: got %b want 0", i, bus.in_ready); end
      @(posedge clk);
      @(negedge clk);
      n_cmp++;
      if (bus.out_valid !== 1'b1) begin n_err++; $display("FAIL bp_out_valid[%0d]: got %b want 1", i, bus.out_valid); end
      n_cmp++;
      if ({bus.err, bus.cout, bus.sum} !== exp) begin
        n_err++; $display("FAIL bp_hold[%0d]: got %h want %h", i, {bus.err, bus.cout, bus.sum}, exp);
      end
    end
    bus.in_valid = 1'b0;
    handshake();
    n_cmp++;
    if (dbg_state !== IDLE) begin n_err++; $display("FAIL bp_not_accepted: got %0d want %0d", dbg_state, IDLE); end
    n_cmp++;
    if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL bp_valid_drop: got %b want 0", bus.out_valid); end
  endtask

  task automatic test_invalid();
    int lat;
    logic [W+1:0] res, exp;
    exp_q.push_back({1'b1, 1'b0, 16'h0100});
    drive_op(16'h00A0, 16'h0000, 1'b0);
    wait_result(lat, res);
    exp = exp_q.pop_front();
    n_cmp++;
    if (res !== exp) begin n_err++; $display("FAIL invalid_digit: got %h want %h", res, exp); end
    handshake();
  endtask

  task automatic test_reset_mid_run();
    int lat;
    logic [W+1:0] res, exp;
    drive_op(16'h1111, 16'h2222, 1'b0);
    repeat (2) @(negedge clk);
    n_cmp++;
    if (dbg_state !== RUN) begin n_err++; $display("FAIL rst_run_state: got %0d want %0d", dbg_state, RUN); end
    rst_n = 1'b0;
    n_cmp++;
    if (bus.in_ready !== 1'b0) begin n_err++; $display("FAIL rst_run_ready_low: got %b want 0", bus.in_ready); end
    @(negedge clk);
    n_cmp++;
    if ({bus.out_valid, bus.err, bus.cout, bus.sum} !== 19'h0) begin
      n_err++; $display("FAIL rst_run_zeroed: got %h want 0", {bus.out_valid, bus.err, bus.cout, bus.sum});
    end
    n_cmp++;
    if (dbg_state !== IDLE) begin n_err++; $display("FAIL rst_run_idle: got %0d want %0d", dbg_state, IDLE); end
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      n_cmp++;
      if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL rst_run_no_valid[%0d]: got %b want 0", i, bus.out_valid); end
    end
    n_cmp++;
    if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL rst_run_ready: got %b want 1", bus.in_ready); end
    exp_q.push_back({1'b0, 1'b0, 16'h0010});
    drive_op(16'h0005, 16'h0005, 1'b0);
    wait_result(lat, res);
    exp = exp_q.pop_front();
    n_cmp++;
    if (res !== exp) begin n_err++; $display("FAIL rst_run_next_op: got %h want %h", res, exp); end
    handshake();
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.cin       = 1'b0;
    test_reset();
    test_basic();
    test_ripple();
    test_back_to_back();
    test_backpressure();
    test_invalid();
    test_reset_mid_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
